// File: rtl/vim828_text_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : vim828_text_writer_if
// Description : Byte-stream valid/ready handshake into the VIM828 text writer.
//               The source drives Data_i/Valid_i and the writer drives Ready_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface vim828_text_writer_if;
    logic [7:0] Data_i;
    logic       Valid_i;
    logic       Ready_o;

    modport master (output Data_i, output Valid_i, input Ready_o);
    modport slave  (input Data_i, input Valid_i, output Ready_o);
endinterface
`default_nettype wire

// File: rtl/vim828_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : vim828_text_writer
// Description : ASCII character stream to eight 14-segment bitmaps plus
//               decimal points for the VIM828 LCD driver. Eight-position text
//               buffer with cursor, clear/home/backspace control codes, and a
//               wrap or scroll end-of-line policy selected by SCROLL.
// Revision    : 1.0 - initial release
// ============================================================================
// Segment bit order NMLK_JIHGF_EDCBA (bit0 = A):
//   A top, B upper right, C lower right, D bottom, E lower left, F upper left,
//   G left middle bar, H right middle bar, I upper-left diagonal,
//   J upper vertical, K upper-right diagonal, L lower-right diagonal,
//   M lower vertical, N lower-left diagonal.
// Internally position 0 is the leftmost digit (Segments7_o).
module vim828_text_writer #(
    parameter int SCROLL = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    vim828_text_writer_if.slave     bus,
    output logic [13:0]             Segments7_o,
    output logic [13:0]             Segments6_o,
    output logic [13:0]             Segments5_o,
    output logic [13:0]             Segments4_o,
    output logic [13:0]             Segments3_o,
    output logic [13:0]             Segments2_o,
    output logic [13:0]             Segments1_o,
    output logic [13:0]             Segments0_o,
    output logic [7:0]              DecimalPoints_o,
    output logic                    Changed_o
);

    localparam logic [7:0] c_CH_DOT   = 8'h2E;
    localparam logic [7:0] c_CH_CLEAR = 8'h0C;
    localparam logic [7:0] c_CH_HOME  = 8'h0D;
    localparam logic [7:0] c_CH_BKSP  = 8'h08;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic [7:0]  r_byte;
    logic [13:0] r_seg [8];
    logic [7:0]  r_dp;
    logic [3:0]  r_cursor;
    logic        r_dot_allowed;

    logic [13:0] w_seg [8];
    logic [7:0]  w_dp;
    logic [3:0]  w_cursor;
    logic        w_dot_allowed;
    logic        w_changed;
    logic        w_do_write;
    logic [13:0] w_pattern;
    logic        w_pattern_dp;
    logic [3:0]  w_pos;
    logic [2:0]  w_prev;

    // 14-segment font; lowercase letters fold onto uppercase
    function automatic logic [13:0] f_font(input logic [7:0] ch);
        logic [7:0] u;
        u = (ch >= 8'h61 && ch <= 8'h7A) ? (ch - 8'h20) : ch;
        case (u)
            8'h2D: f_font = 14'h00C0; // '-'
            8'h30: f_font = 14'h243F;
            8'h31: f_font = 14'h0006;
            8'h32: f_font = 14'h00DB;
            8'h33: f_font = 14'h008F;
            8'h34: f_font = 14'h00E6;
            8'h35: f_font = 14'h00ED;
            8'h36: f_font = 14'h00FD;
            8'h37: f_font = 14'h0007;
            8'h38: f_font = 14'h00FF;
            8'h39: f_font = 14'h00EF;
            8'h41: f_font = 14'h00F7;
            8'h42: f_font = 14'h128F;
            8'h43: f_font = 14'h0039;
            8'h44: f_font = 14'h120F;
            8'h45: f_font = 14'h0079;
            8'h46: f_font = 14'h0071;
            8'h47: f_font = 14'h00BD;
            8'h48: f_font = 14'h00F6;
            8'h49: f_font = 14'h1209;
            8'h4A: f_font = 14'h001E;
            8'h4B: f_font = 14'h0C70;
            8'h4C: f_font = 14'h0038;
            8'h4D: f_font = 14'h0536;
            8'h4E: f_font = 14'h0936;
            8'h4F: f_font = 14'h003F;
            8'h50: f_font = 14'h00F3;
            8'h51: f_font = 14'h083F;
            8'h52: f_font = 14'h08F3;
            8'h53: f_font = 14'h00ED;
            8'h54: f_font = 14'h1201;
            8'h55: f_font = 14'h003E;
            8'h56: f_font = 14'h2430;
            8'h57: f_font = 14'h2836;
            8'h58: f_font = 14'h2D00;
            8'h59: f_font = 14'h1500;
            8'h5A: f_font = 14'h2409;
            default: f_font = 14'h0000;
        endcase
    endfunction

    // Next state, next buffer/cursor and change detection for the latched byte
    always_comb begin
        w_state_next  = r_state;
        w_seg         = r_seg;
        w_dp          = r_dp;
        w_cursor      = r_cursor;
        w_dot_allowed = r_dot_allowed;
        w_changed     = 1'b0;
        w_do_write    = 1'b0;
        w_pattern     = 14'h0000;
        w_pattern_dp  = 1'b0;
        w_pos         = r_cursor;
        w_prev        = r_cursor[2:0] - 3'd1;

        case (r_state)
            IDLE: begin
                if (bus.Valid_i && r_ready) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = IDLE;
                if (r_byte == c_CH_DOT) begin
                    // A dot attaches to the previous character once; otherwise
                    // it occupies a blank position of its own.
                    if (r_dot_allowed && (r_cursor != 4'd0)) begin
                        w_dp[w_prev] = 1'b1;
                    end else begin
                        w_do_write   = 1'b1;
                        w_pattern_dp = 1'b1;
                    end
                    w_dot_allowed = 1'b0;
                end else if (r_byte >= 8'h20 && r_byte <= 8'h7E) begin
                    w_do_write    = 1'b1;
                    w_pattern     = f_font(r_byte);
                    w_dot_allowed = 1'b1;
                end else begin
                    w_dot_allowed = 1'b0;
                    case (r_byte)
                        c_CH_CLEAR: begin
                            for (int i = 0; i < 8; i++) begin
                                w_seg[i] = 14'h0000;
                            end
                            w_dp     = 8'h00;
                            w_cursor = 4'd0;
                        end
                        c_CH_HOME: w_cursor = 4'd0;
                        c_CH_BKSP: begin
                            if (r_cursor != 4'd0) begin
                                w_cursor = r_cursor - 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end

                if (w_do_write) begin
                    // Cursor 8 is past the end: scroll left or wrap first
                    if (r_cursor == 4'd8) begin
                        if (SCROLL != 0) begin
                            for (int i = 0; i < 7; i++) begin
                                w_seg[i] = r_seg[i+1];
                                w_dp[i]  = r_dp[i+1];
                            end
                            w_seg[7] = 14'h0000;
                            w_dp[7]  = 1'b0;
                            w_pos    = 4'd7;
                        end else begin
                            w_pos = 4'd0;
                        end
                    end
                    w_seg[w_pos[2:0]] = w_pattern;
                    w_dp[w_pos[2:0]]  = w_pattern_dp;
                    w_cursor          = w_pos + 4'd1;
                end

                w_changed = (w_dp != r_dp);
                for (int i = 0; i < 8; i++) begin
                    if (w_seg[i] != r_seg[i]) begin
                        w_changed = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, handshake, byte latch and display buffer registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_ready       <= 1'b0;
            r_byte        <= 8'h00;
            r_dp          <= 8'h00;
            r_cursor      <= 4'd0;
            r_dot_allowed <= 1'b0;
            Changed_o     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_seg[i] <= 14'h0000;
            end
        end else begin
            r_state       <= w_state_next;
            r_ready       <= (w_state_next == IDLE);
            if (r_state == IDLE && bus.Valid_i && r_ready) begin
                r_byte <= bus.Data_i;
            end
            r_seg         <= w_seg;
            r_dp          <= w_dp;
            r_cursor      <= w_cursor;
            r_dot_allowed <= w_dot_allowed;
            Changed_o     <= w_changed;
        end
    end

    assign bus.Ready_o     = r_ready;
    assign Segments7_o     = r_seg[0];
    assign Segments6_o     = r_seg[1];
    assign Segments5_o     = r_seg[2];
    assign Segments4_o     = r_seg[3];
    assign Segments3_o     = r_seg[4];
    assign Segments2_o     = r_seg[5];
    assign Segments1_o     = r_seg[6];
    assign Segments0_o     = r_seg[7];
    assign DecimalPoints_o = {r_dp[0], r_dp[1], r_dp[2], r_dp[3],
                              r_dp[4], r_dp[5], r_dp[6], r_dp[7]};

endmodule
`default_nettype wire

// File: tb/tb_vim828_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vim828_text_writer
// Description : Self-checking bench for vim828_text_writer. Two instances
//               (scroll and wrap) receive the same byte stream; each is
//               compared against its own text-buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vim828_text_writer;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    vim828_text_writer_if bus_s ();
    vim828_text_writer_if bus_w ();

    logic [13:0] seg_s [8];
    logic [13:0] seg_w [8];
    logic [7:0]  dp_s, dp_w;
    logic        ch_s, ch_w;

    vim828_text_writer #(.SCROLL(1)) dut_scroll (
        .Clock(Clock), .Reset(Reset), .bus(bus_s),
        .Segments7_o(seg_s[7]), .Segments6_o(seg_s[6]),
        .Segments5_o(seg_s[5]), .Segments4_o(seg_s[4]),
        .Segments3_o(seg_s[3]), .Segments2_o(seg_s[2]),
        .Segments1_o(seg_s[1]), .Segments0_o(seg_s[0]),
        .DecimalPoints_o(dp_s), .Changed_o(ch_s)
    );

    vim828_text_writer #(.SCROLL(0)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .bus(bus_w),
        .Segments7_o(seg_w[7]), .Segments6_o(seg_w[6]),
        .Segments5_o(seg_w[5]), .Segments4_o(seg_w[4]),
        .Segments3_o(seg_w[3]), .Segments2_o(seg_w[2]),
        .Segments1_o(seg_w[1]), .Segments0_o(seg_w[0]),
        .DecimalPoints_o(dp_w), .Changed_o(ch_w)
    );

    int checks   = 0;
    int failures = 0;

    // Text-buffer model: index 0 = scroll instance, 1 = wrap instance;
    // position 0 is the leftmost character.
    logic [13:0] mbuf [2][8];
    bit          mdp  [2][8];
    int          mcur [2];
    bit          mdot [2];

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] ref_font(input logic [7:0] c);
        case (c)
            "1":      ref_font = 14'h0006;
            "7":      ref_font = 14'h0007;
            "8":      ref_font = 14'h00FF;
            "-":      ref_font = 14'h00C0;
            "A", "a": ref_font = 14'h00F7;
            default:  ref_font = 14'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 8; p++) begin
                mbuf[k][p] = 14'h0;
                mdp[k][p]  = 1'b0;
            end
            mcur[k] = 0;
            mdot[k] = 1'b0;
        end
    endtask

    task automatic model_write(input int k, input logic [13:0] pat, input bit d);
        if (mcur[k] == 8) begin
            if (k == 0) begin
                for (int p = 0; p < 7; p++) begin
                    mbuf[k][p] = mbuf[k][p+1];
                    mdp[k][p]  = mdp[k][p+1];
                end
                mbuf[k][7] = 14'h0;
                mdp[k][7]  = 1'b0;
                mcur[k]    = 7;
            end else begin
                mcur[k] = 0;
            end
        end
        mbuf[k][mcur[k]] = pat;
        mdp[k][mcur[k]]  = d;
        mcur[k]++;
    endtask

    task automatic model_byte(input int k, input logic [7:0] b, output bit chg);
        logic [13:0] ob [8];
        bit          od [8];
        for (int p = 0; p < 8; p++) begin
            ob[p] = mbuf[k][p];
            od[p] = mdp[k][p];
        end
        if (b == 8'h2E) begin
            if (mdot[k] && mcur[k] > 0) mdp[k][mcur[k]-1] = 1'b1;
            else                        model_write(k, 14'h0, 1'b1);
            mdot[k] = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            model_write(k, ref_font(b), 1'b0);
            mdot[k] = 1'b1;
        end else begin
            mdot[k] = 1'b0;
            if (b == 8'h0C) begin
                for (int p = 0; p < 8; p++) begin
                    mbuf[k][p] = 14'h0;
                    mdp[k][p]  = 1'b0;
                end
                mcur[k] = 0;
            end else if (b == 8'h0D) begin
                mcur[k] = 0;
            end else if (b == 8'h08) begin
                if (mcur[k] > 0) mcur[k]--;
            end
        end
        chg = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (ob[p] != mbuf[k][p] || od[p] != mdp[k][p]) chg = 1'b1;
        end
    endtask

    function automatic logic [119:0] model_vec(input int k);
        logic [119:0] v;
        v = '0;
        for (int p = 0; p < 8; p++) begin
            v[119-14*p -: 14] = mbuf[k][p];
            v[7-p]            = mdp[k][p];
        end
        return v;
    endfunction

    function automatic logic [119:0] dut_vec(input int k);
        logic [119:0] v;
        for (int p = 0; p < 8; p++) begin
            v[119-14*p -: 14] = (k == 0) ? seg_s[7-p] : seg_w[7-p];
        end
        v[7:0] = (k == 0) ? dp_s : dp_w;
        return v;
    endfunction

    // Send one byte to both instances and check the full display afterwards
    task automatic send(input logic [7:0] b);
        int n;
        bit ec0, ec1;
        bus_s.Data_i = b;  bus_s.Valid_i = 1'b1;
        bus_w.Data_i = b;  bus_w.Valid_i = 1'b1;
        n = 0;
        while (!bus_s.Ready_o && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        if (!bus_s.Ready_o) begin
            check("ready_timeout", 120'(bus_s.Ready_o), 120'd1);
            bus_s.Valid_i = 1'b0;
            bus_w.Valid_i = 1'b0;
            return;
        end
        @(posedge Clock); #1;
        bus_s.Valid_i = 1'b0;  bus_s.Data_i = 8'($urandom);
        bus_w.Valid_i = 1'b0;  bus_w.Data_i = bus_s.Data_i;
        check("exec_ready_changed", 120'({bus_s.Ready_o, bus_w.Ready_o, ch_s, ch_w}), 120'd0);
        model_byte(0, b, ec0);
        model_byte(1, b, ec1);
        @(posedge Clock); #1;
        check("contents_scroll", dut_vec(0), model_vec(0));
        check("contents_wrap", dut_vec(1), model_vec(1));
        check("changed_ready", 120'({ch_s, ch_w, bus_s.Ready_o, bus_w.Ready_o}),
              120'({ec0, ec1, 2'b11}));
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [13:0] s7;
        logic [13:0] s6;
        logic [7:0]  dp;
        bit          chg;
    } vec_t;

    vec_t tbl [19];
    logic [7:0] pool [16];

    initial begin
        tbl[0]  = '{8'h0C, 14'h0000, 14'h0000, 8'h00, 1'b0};
        tbl[1]  = '{"1",   14'h0006, 14'h0000, 8'h00, 1'b1};
        tbl[2]  = '{"7",   14'h0006, 14'h0007, 8'h00, 1'b1};
        tbl[3]  = '{8'h0C, 14'h0000, 14'h0000, 8'h00, 1'b1};
        tbl[4]  = '{"7",   14'h0007, 14'h0000, 8'h00, 1'b1};
        tbl[5]  = '{".",   14'h0007, 14'h0000, 8'h80, 1'b1};
        tbl[6]  = '{".",   14'h0007, 14'h0000, 8'hC0, 1'b1};
        tbl[7]  = '{8'h0D, 14'h0007, 14'h0000, 8'hC0, 1'b0};
        tbl[8]  = '{"1",   14'h0006, 14'h0000, 8'h40, 1'b1};
        tbl[9]  = '{8'h08, 14'h0006, 14'h0000, 8'h40, 1'b0};
        tbl[10] = '{8'h08, 14'h0006, 14'h0000, 8'h40, 1'b0};
        tbl[11] = '{"7",   14'h0007, 14'h0000, 8'h40, 1'b1};
        tbl[12] = '{8'h1B, 14'h0007, 14'h0000, 8'h40, 1'b0};
        tbl[13] = '{"a",   14'h0007, 14'h00F7, 8'h00, 1'b1};
        tbl[14] = '{".",   14'h0007, 14'h00F7, 8'h40, 1'b1};
        tbl[15] = '{".",   14'h0007, 14'h00F7, 8'h60, 1'b1};
        tbl[16] = '{8'h0D, 14'h0007, 14'h00F7, 8'h60, 1'b0};
        tbl[17] = '{"7",   14'h0007, 14'h00F7, 8'h60, 1'b0};
        tbl[18] = '{"#",   14'h0007, 14'h0000, 8'h20, 1'b1};

        pool = '{"1", "7", "8", "-", " ", "A", "a", "#",
                 ".", ".", ".", 8'h08, 8'h0D, 8'h0C, 8'h1B, 8'h7F};

        bus_s.Valid_i = 1'b0;  bus_s.Data_i = 8'h00;
        bus_w.Valid_i = 1'b0;  bus_w.Data_i = 8'h00;
        model_reset();

        // Reset held three cycles: everything low, including Ready_o
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            check("reset_outputs", {dut_vec(0) | dut_vec(1)} |
                  120'({bus_s.Ready_o, bus_w.Ready_o, ch_s, ch_w}), 120'd0);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("ready_after_reset", 120'({bus_s.Ready_o, bus_w.Ready_o}), 120'd3);

        // Table-driven basic function
        for (int i = 0; i < 19; i++) begin
            send(tbl[i].data);
            check($sformatf("tbl%0d", i), {seg_s[7], seg_s[6], dp_s, 1'b0, ch_s, 76'd0},
                  {tbl[i].s7, tbl[i].s6, tbl[i].dp, 1'b0, tbl[i].chg, 76'd0});
        end

        // Eight '1's fill the line; a ninth '1' leaves the display unchanged
        send(8'h0C);
        for (int i = 0; i < 8; i++) send("1");
        check("full_line", dut_vec(0), {{8{14'h0006}}, 8'h00});
        send("1");
        check("ninth_no_pulse", 120'({ch_s, ch_w}), 120'd0);
        send("7");
        check("scroll_after_nine", dut_vec(0), {{7{14'h0006}}, 14'h0007, 8'h00});

        // End of line: scroll shifts left, wrap overwrites position 0
        send(8'h0C);
        for (int i = 0; i < 8; i++) send("1");
        send("7");
        check("scroll_eol", dut_vec(0), {{7{14'h0006}}, 14'h0007, 8'h00});
        check("wrap_eol", dut_vec(1), {14'h0007, {7{14'h0006}}, 8'h00});
        send("7");
        check("wrap_cursor1", dut_vec(1), {14'h0007, 14'h0007, {6{14'h0006}}, 8'h00});

        // Reset during EXEC drops the byte
        send(8'h0C);
        bus_s.Data_i = "1";  bus_s.Valid_i = 1'b1;
        bus_w.Data_i = "1";  bus_w.Valid_i = 1'b1;
        @(posedge Clock); #1;
        bus_s.Valid_i = 1'b0;  bus_w.Valid_i = 1'b0;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        check("reset_in_exec", {dut_vec(0) | dut_vec(1)} |
              120'({bus_s.Ready_o, bus_w.Ready_o, ch_s, ch_w}), 120'd0);
        @(posedge Clock); #1;
        check("after_reset_exec", {dut_vec(0) | dut_vec(1)} | 120'({ch_s, ch_w}), 120'd0);
        check("ready_after_reset_exec", 120'({bus_s.Ready_o, bus_w.Ready_o}), 120'd3);

        // Randomised stream with idle gaps against the model
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge Clock); #1;
            end
            send(pool[$urandom_range(0, 15)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
